// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide sequencer: one result bit per cycle.
// MUL uses shift-add, DIV uses restoring division, and FIX applies the signs.
module muldiv_seq #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op,
   input  logic [N-1:0] s,
   input  logic [N-1:0] t,
   input  logic         flush,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] out,
   output logic [N-1:0] hi,
   output logic         overflow
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

   state_t          state_q, state_d;
   logic            op_q, op_d;
   logic            neg_q, neg_d;
   logic            sneg_q, sneg_d;
   logic [N-1:0]    opa_q, opa_d;
   logic [N-1:0]    opb_q, opb_d;
   logic [2*N-1:0]  acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    out_q, out_d;
   logic [N-1:0]    hi_q, hi_d;
   logic            ovf_q, ovf_d;
   logic            done_q, done_d;

   logic [N-1:0]    abs_s, abs_t;
   logic [N:0]      rem_sh;
   logic [N-1:0]    diff;
   logic [N:0]      sum;
   logic [2*N-1:0]  prod;
   logic [N-1:0]    quot;
   logic [N-1:0]    rem;

   // The magnitude of the most negative value wraps onto itself, which reads correctly as unsigned.
   assign abs_s = s[N-1] ? -s : s;
   assign abs_t = t[N-1] ? -t : t;

   // DIV keeps the remainder in acc[2N-1:N] and the dividend/quotient in acc[N-1:0].
   assign rem_sh = {acc_q[2*N-1:N], acc_q[N-1]};
   assign diff   = rem_sh[N-1:0] - opa_q;
   assign sum    = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opa_q} : {(N+1){1'b0}});
   assign prod   = neg_q ? -acc_q : acc_q;
   assign quot   = neg_q ? -acc_q[N-1:0] : acc_q[N-1:0];
   assign rem    = sneg_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      neg_d   = neg_q;
      sneg_d  = sneg_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      hi_d    = hi_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               if (op && (t == '0)) begin
                  done_d = 1'b1;
                  out_d  = '0;
                  hi_d   = s;
                  ovf_d  = 1'b1;
               end else begin
                  op_d    = op;
                  neg_d   = s[N-1] ^ t[N-1];
                  sneg_d  = s[N-1];
                  opa_d   = op ? abs_t : abs_s;
                  opb_d   = op ? abs_s : abs_t;
                  state_d = PREP;
               end
            end
         end
         PREP: begin
            acc_d   = {{N{1'b0}}, opb_q};
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            if (op_q) begin
               if (rem_sh >= {1'b0, opa_q})
                  acc_d = {diff, acc_q[N-2:0], 1'b1};
               else
                  acc_d = {rem_sh[N-1:0], acc_q[N-2:0], 1'b0};
            end else begin
               acc_d = {sum, acc_q[N-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N-1))
               state_d = FIX;
         end
         FIX: begin
            if (op_q) begin
               out_d = quot;
               hi_d  = rem;
               // Only a positive 2^(N-1) quotient is unrepresentable.
               ovf_d = !neg_q && acc_q[N-1];
            end else begin
               out_d = prod[N-1:0];
               hi_d  = prod[2*N-1:N];
               ovf_d = prod[2*N-1:N] != {N{prod[N-1]}};
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
         done_d  = 1'b0;
         out_d   = out_q;
         hi_d    = hi_q;
         ovf_d   = ovf_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= 1'b0;
         neg_q   <= 1'b0;
         sneg_q  <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         hi_q    <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         sneg_q  <= sneg_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         hi_q    <= hi_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign out      = out_q;
   assign hi       = hi_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed cases plus random operations checked against
// a 64-bit arithmetic reference model.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] s = '0;
   logic [31:0] t = '0;
   logic        busy, done, overflow;
   logic [31:0] out, hi;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_out = '0;
   logic [31:0] last_hi = '0;
   logic        last_ovf = 1'b0;

   muldiv_seq #(.N(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .s(s), .t(t),
      .flush(flush), .busy(busy), .done(done), .out(out), .hi(hi),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: plain signed 64-bit arithmetic.
   task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eo, output logic [31:0] eh, output logic ev);
      longint sa, sb, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!o) begin
         p  = sa * sb;
         eo = p[31:0];
         eh = p[63:32];
         ev = (p < -longint'(64'sh80000000)) || (p > longint'(64'sh7FFFFFFF));
      end else if (b == 32'd0) begin
         eo = 32'd0; eh = a; ev = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         eo = q[31:0];
         eh = r[31:0];
         ev = (q > longint'(64'sh7FFFFFFF));
      end
   endtask

   // Drives start at the current negedge and waits for done; returns on the done negedge.
   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] eo, eh;
      logic        ev;
      int e, bc, exp_e, exp_b;
      model(o, a, b, eo, eh, ev);
      exp_e = (o && b == 32'd0) ? 0 : 34;
      exp_b = (o && b == 32'd0) ? 0 : 34;
      start = 1'b1; op = o; s = a; t = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      e = 0; bc = 0;
      while (!done && e < 100) begin
         if (busy) bc++;
         e++;
         @(negedge clk);
      end
      chk({tag, "_done_edge"}, 64'(e), 64'(exp_e));
      chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_b));
      chk({tag, "_out"}, 64'(out), 64'(eo));
      chk({tag, "_hi"}, 64'(hi), 64'(eh));
      chk({tag, "_ovf"}, 64'(overflow), 64'(ev));
      $display("op=%0d s=%h t=%h -> out=%h hi=%h ovf=%0b (%s)", o, a, b, out, hi, overflow, tag);
      last_out = eo; last_hi = eh; last_ovf = ev;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0: return 32'($urandom % 16);
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd0;
         4: return -32'($urandom % 16);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int dn;
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1'b0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
      @(negedge clk);
      run_op(1'b0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
      @(negedge clk);
      run_op(1'b1, -32'd7, 32'd2, "div_-7/2");
      @(negedge clk);
      run_op(1'b1, 32'd7, -32'd2, "div_7/-2");
      @(negedge clk);
      run_op(1'b1, 32'd5, 32'd0, "div_by_0");
      @(negedge clk);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_qovf");
      @(negedge clk);
      run_op(1'b0, 32'd3, 32'd4, "mul_3x4");
      run_op(1'b1, 32'd100, 32'd7, "div_b2b");

      for (int i = 0; i < 30; i++) begin
         logic o;
         logic [31:0] a, b;
         o = 1'($urandom % 2);
         a = pick();
         b = pick();
         if ($urandom % 2) @(negedge clk);
         run_op(o, a, b, $sformatf("rand%0d", i));
      end

      // Flush mid-operation with a simultaneous start.
      @(negedge clk);
      start = 1'b1; op = 1'b0; s = 32'd123; t = 32'd456;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1; start = 1'b1; s = 32'd9; t = 32'd9;
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      dn = 0;
      for (int c = 0; c < 50; c++) begin
         if (done || busy) dn++;
         @(negedge clk);
      end
      chk("flush_no_activity", 64'(dn), 64'd0);
      chk("flush_out", 64'(out), 64'(last_out));
      chk("flush_hi", 64'(hi), 64'(last_hi));
      chk("flush_ovf", 64'(overflow), 64'(last_ovf));
      $display("flush: busy=%0b out=%h hi=%h ovf=%0b", busy, out, hi, overflow);

      // Asynchronous reset mid-RUN.
      start = 1'b1; op = 1'b0; s = 32'h1234; t = 32'h5678;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_out", 64'(out), 64'd0);
      chk("arst_hi", 64'(hi), 64'd0);
      chk("arst_ovf", 64'(overflow), 64'd0);
      $display("async reset: busy=%0b out=%h hi=%h", busy, out, hi);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 32'd2, 32'd2, "mul_2x2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multi-cycle sequencer for signed multiply and divide, sitting beside the single-cycle ALU in the execute stage. It accepts one operation per start handshake and computes one bit per cycle. It returns a 2N-bit result (low word plus high word/remainder) and an overflow flag. While busy, the pipeline control stalls on `busy`.

## Interface
- N, 32, operand and result width
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  request; sampled only when the block is not busy
- op  in  1  0 = MUL, 1 = DIV, both signed two's complement
- s  in  N  multiplicand or dividend, sampled with start
- t  in  N  multiplier or divisor, sampled with start
- flush  in  1  synchronous abort; higher priority than start
- busy  out  1  operation in progress; pipeline must stall
- done  out  1  single-cycle pulse; results valid
- out  out  N  MUL: product[N-1:0]; DIV: quotient
- hi  out  N  MUL: product[2N-1:N]; DIV: remainder
- overflow  out  1  MUL: hi != {N{out[N-1]}}; DIV: divide-by-zero or quotient overflow

## Operation
- States: IDLE, PREP, RUN, FIX.
- IDLE
  - busy = 0.
  - start = 1 with op = DIV and t = 0 → stay in IDLE. Next cycle: done = 1, out = 0, hi = s, overflow = 1.
  - Any other start → latch op, the operand signs, |s| and |t| (N-bit unsigned; |−2^(N−1)| = 2^(N−1)). Go to PREP.
- PREP: clear the 2N-bit accumulator and the bit counter. Load the unsigned operands. Go to RUN.
- RUN: exactly N cycles, counter 0..N−1.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring shift-subtract, one quotient bit per cycle.
  - After the cycle with counter = N−1, go to FIX.
- FIX
  - MUL: negate the 2N-bit product if sign(s) != sign(t).
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend. The quotient truncates toward zero.
  - DIV quotient overflow (s = 0x80000000, t = 0xFFFFFFFF): out = 0x80000000, hi = 0, overflow = 1.
  - Go to IDLE. Register out, hi and overflow, and pulse done.
- Outputs hold their last values until the next done.
- A start asserted in the same cycle as done is accepted (back-to-back).
- start while busy = 1 is ignored; the issuer must hold or re-issue it.
- flush in any state → IDLE next cycle. No done pulse. out, hi and overflow are unchanged.
- flush and start together → the start is dropped.
- rst_n low, at any time including mid-RUN:
  - state = IDLE, busy = 0, done = 0, out = 0, hi = 0, overflow = 0, counter = 0.
  - Takes effect immediately, with no clock needed.
- busy is decoded from the state register (PREP, RUN or FIX), not a separate flop.
- done is a registered one-cycle pulse.

## Timing
- Edge E0 samples start in IDLE.
  - Normal op: PREP after E0, RUN after E1 through E(N), FIX after E(N+1), IDLE after E(N+2).
  - done = 1 during the cycle after E(N+2): latency N+2 = 34 cycles.
  - busy = 1 from after E0 through after E(N+1): N+2 cycles.
  - Divide-by-zero: done = 1 in the cycle after E0 (latency 1); busy never asserts.
- Throughput: one operation per N+2 cycles with back-to-back start.
- Arithmetic:
  - Accumulator width is 2N for MUL and N+1 for the DIV partial remainder.
  - No truncation before FIX.
- Reset is asynchronous on assertion. Deassertion is synchronized externally; the first start is accepted at the first edge after rst_n rises.

## Test plan
- MUL 7 × −3 (s = 7, t = 0xFFFFFFFD) → done at cycle 34, out = 0xFFFFFFEB, hi = 0xFFFFFFFF, overflow = 0. busy is high for exactly 34 cycles.
- MUL 0x00010000 × 0x00010000 → out = 0x00000000, hi = 0x00000001, overflow = 1.
- DIV −7 / 2 → out = 0xFFFFFFFD, hi = 0xFFFFFFFF, overflow = 0.
- DIV 7 / −2 → out = 0xFFFFFFFD, hi = 0x00000001.
- DIV 5 / 0 → done one cycle after start, out = 0, hi = 5, overflow = 1, busy stays 0.
- DIV 0x80000000 / 0xFFFFFFFF → out = 0x80000000, hi = 0, overflow = 1.
- MUL 3 × 4, then start DIV 100 / 7 in the done cycle → out = 12, then out = 14, hi = 2. The second done comes 34 cycles later.
- Start MUL, pulse flush at cycle 10:
  - busy drops the next cycle, no done, outputs keep their prior values.
  - A start re-issued in the same cycle is ignored.
  - Drop rst_n at cycle 20 of a new MUL: all outputs are 0 immediately. After release, MUL 2 × 2 → out = 4.
